// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding and
// the active-low one-hot generator used by both direct and scan paths.
package scan_decoder_pkg;

  localparam int MAX_OUT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } scan_state_e;

  function automatic logic [MAX_OUT-1:0] onehot_n(input int unsigned idx, input int unsigned n);
    logic [MAX_OUT-1:0] v;
    v = '1;
    if (idx < n && idx < MAX_OUT) v[idx[7:0]] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter for scan mode: counts 0..lim and wraps, with clear, load and hold.
// tc flags the last cycle of the dwell period.
module scan_dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               ld,
  input  logic [DWELL_W-1:0] ld_val,
  input  logic               hold,
  input  logic [DWELL_W-1:0] lim,
  output logic [DWELL_W-1:0] cnt,
  output logic               tc
);

  assign tc = (cnt == lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (ld)    cnt <= ld_val;
    else if (!hold) cnt <= tc ? '0 : cnt + DWELL_W'(1);
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered 1-of-N active-low decoder with direct and scan modes.
// Optional SCAN_DECODER_BLANK_EN inserts an all-high cycle at every scan index advance.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N_OUT   = 10,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_cs,
  input  logic [1:0]         i_n_cs,
  input  logic               i_mode,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_load_valid,
  output logic               o_load_ready,
  output logic [N_OUT-1:0]   o_n_out,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_invalid,
  output logic               o_wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  scan_state_e        state, state_nxt;
  logic [SEL_W-1:0]   idx, idx_nxt, sel_nxt;
  logic [DWELL_W-1:0] dwell_reg, dwell_cnt;
  logic               enable, sel_ok, load_fire, cnt_tc, count_en, advance;
  logic               blank, blank_nxt, wrap_nxt, invalid_nxt;
  logic [N_OUT-1:0]   n_out_nxt;

  assign enable       = i_cs & ~i_n_cs[0] & ~i_n_cs[1];
  assign sel_ok       = int'(i_sel) < N_OUT;
  assign o_load_ready = (state != RUN);
  assign load_fire    = i_load_valid & o_load_ready;
  // Count only in cycles that start and end in RUN, so pause/resume edges do not consume dwell.
  assign count_en     = (state == RUN) && (state_nxt == RUN) && !blank;
  assign advance      = count_en & cnt_tc;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_mode) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (enable)  state_nxt = RUN;
        RUN:     if (!enable) state_nxt = PAUSE;
        PAUSE:   if (enable)  state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (load_fire)    idx_nxt = sel_ok ? i_sel : '0;
    else if (advance) idx_nxt = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      idx       <= '0;
      dwell_reg <= '0;
    end else begin
      idx <= idx_nxt;
      if (load_fire) dwell_reg <= i_dwell;
    end
  end

  scan_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (i_clk),
    .rst_n (i_n_rst),
    .clr   (state_nxt == IDLE),
    .ld    (load_fire),
    .ld_val('0),
    .hold  (!count_en),
    .lim   (dwell_reg),
    .cnt   (dwell_cnt),
    .tc    (cnt_tc)
  );

`ifdef SCAN_DECODER_BLANK_EN
  always_comb begin
    blank_nxt = blank;
    if (state_nxt == IDLE || load_fire)           blank_nxt = 1'b0;
    else if (advance)                             blank_nxt = 1'b1;
    else if (state == RUN && state_nxt == RUN)    blank_nxt = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) blank <= 1'b0;
    else          blank <= blank_nxt;
  end

  // Wrap is reported when index 0 is actually driven, i.e. as the blank after the wrap ends.
  assign wrap_nxt = blank && (state == RUN) && (state_nxt == RUN) && (idx == '0);
`else
  assign blank     = 1'b0;
  assign blank_nxt = 1'b0;
  assign wrap_nxt  = advance && (idx == LAST_IDX);
`endif

  always_comb begin
    n_out_nxt   = '1;
    invalid_nxt = 1'b0;
    sel_nxt     = idx_nxt;
    case (state_nxt)
      IDLE: begin
        if (enable) n_out_nxt = N_OUT'(onehot_n(32'(i_sel), N_OUT));
        invalid_nxt = enable & ~sel_ok;
        sel_nxt     = i_sel;
      end
      RUN:     if (!blank_nxt) n_out_nxt = N_OUT'(onehot_n(32'(idx_nxt), N_OUT));
      default: ;
    endcase
  end

  // Output register stage
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      o_n_out   <= '1;
      o_sel     <= '0;
      o_invalid <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      o_n_out   <= n_out_nxt;
      o_sel     <= sel_nxt;
      o_invalid <= invalid_nxt;
      o_wrap    <= wrap_nxt;
    end
  end

endmodule
